// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
// Shared types and constants for the DAC playback path.
//   state_t      : playback FSM states
//   SAMPLE_W_DEF : default sample width (bits)
//   ADDR_W_DEF   : default SRAM word-address width
//   CNT_W        : width of the serialiser bit counter (counts 0..SAMPLE_W)
// -----------------------------------------------------------------------------
package dac_pkg;

    localparam int unsigned SAMPLE_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF   = 18;
    localparam int unsigned CNT_W        = $clog2(SAMPLE_W_DEF) + 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ARMED,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/dac_piso.sv
// -----------------------------------------------------------------------------
// dac_piso
// Parallel-in / serial-out register, MSB first, with a registered serial output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture din; its MSB appears on sout after this edge
//   shift      : launch the next bit each cycle until all W bits have gone out
//   din        : parallel word
//   sout       : registered serial bit (0 whenever neither loading nor shifting)
//   cnt        : number of bits launched since the last load
//   empty      : all W bits have been launched
// -----------------------------------------------------------------------------
module dac_piso
    import dac_pkg::*;
#(
    parameter int unsigned W = SAMPLE_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [W-1:0]     din,
    output logic             sout,
    output logic [CNT_W-1:0] cnt,
    output logic             empty
);

    logic [W-1:0]     sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sout_q, sout_d;

    assign empty = (cnt_q == CNT_W'(W));
    assign sout  = sout_q;
    assign cnt   = cnt_q;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        sout_d = 1'b0;
        if (load) begin
            // MSB goes straight to the output; the rest waits in sreg.
            sout_d = din[W-1];
            sreg_d = {din[W-2:0], 1'b0};
            cnt_d  = CNT_W'(1);
        end else if (shift && !empty) begin
            sout_d = sreg_q[W-1];
            sreg_d = {sreg_q[W-2:0], 1'b0};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            sout_q <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            sout_q <= sout_d;
        end
    end

endmodule

// File: rtl/dac_playback.sv
// -----------------------------------------------------------------------------
// dac_playback
// Reads samples from the shared SRAM and serialises them MSB first onto the
// codec DACDAT line. The codec is bus master; everything runs on bclk.
// Optional build macro: STEREO_DUP_EN -- re-send each sample in the right
// (daclrc high) phase from a hold copy; otherwise the high phase is silent.
// Ports:
//   bclk     : codec bit clock (only clock)
//   rst_n    : asynchronous active-low reset
//   daclrc   : codec frame clock, low = left/sample slot, high = right
//   play     : 1 = play/continue, 0 = pause
//   rd_data  : SRAM read data, valid the cycle after rd_en
//   addr     : SRAM word address, high-Z unless play=1 and out of reset
//   rd_en    : one-cycle SRAM read strobe
//   dacdat   : serial sample bit
//   busy     : FSM in FETCH, ARMED or SHIFT
//   done     : FSM in DONE (last address played)
// -----------------------------------------------------------------------------
module dac_playback
    import dac_pkg::*;
#(
    parameter int unsigned       SAMPLE_W   = SAMPLE_W_DEF,
    parameter int unsigned       ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = '1
) (
    input  logic                bclk,
    input  logic                rst_n,
    input  logic                daclrc,
    input  logic                play,
    input  logic [SAMPLE_W-1:0] rd_data,
    output logic [ADDR_W-1:0]   addr,
    output logic                rd_en,
    output logic                dacdat,
    output logic                busy,
    output logic                done
);

    state_t              state_q, state_d;
    logic                lrc_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SAMPLE_W-1:0] next_q, next_d;
    logic                last_q, last_d;
    logic                rd_pend_q;
    logic                fs;

    logic                p_load, p_shift, p_empty;
    logic [SAMPLE_W-1:0] p_din;
    logic [CNT_W-1:0]    p_cnt;

`ifdef STEREO_DUP_EN
    logic                rs;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic                rdup_q, rdup_d;    // left copy sent, right copy pending
    logic                right_q, right_d;  // word in the shifter is the right copy
    assign rs = !lrc_q && daclrc;
`endif

    assign fs     = lrc_q && !daclrc;
    assign addr   = (play && rst_n) ? addr_q : {ADDR_W{1'bz}};
    assign busy   = (state_q == FETCH) || (state_q == ARMED) || (state_q == SHIFT);
    assign done   = (state_q == DONE);

    dac_piso #(.W(SAMPLE_W)) u_piso (
        .clk   (bclk),
        .rst_n (rst_n),
        .load  (p_load),
        .shift (p_shift),
        .din   (p_din),
        .sout  (dacdat),
        .cnt   (p_cnt),
        .empty (p_empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        // A read issued last cycle lands in next_q regardless of state.
        next_d  = rd_pend_q ? rd_data : next_q;
        last_d  = last_q;
        rd_en   = 1'b0;
        p_load  = 1'b0;
        p_shift = 1'b0;
        p_din   = next_q;
`ifdef STEREO_DUP_EN
        hold_d  = hold_q;
        rdup_d  = rdup_q;
        right_d = right_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (play) state_d = FETCH;
            end
            FETCH: begin
                if (!play) begin
                    state_d = IDLE;
                end else if (rd_pend_q) begin
                    state_d = ARMED;
                end else begin
                    rd_en = 1'b1;
                end
            end
            ARMED: begin
                if (!play) begin
                    state_d = IDLE;
`ifdef STEREO_DUP_EN
                    // Right copy not yet sent: the word counts as unplayed.
                    if (rdup_q && !last_q) addr_d = addr_q - 1'b1;
                    rdup_d  = 1'b0;
                    right_d = 1'b0;
                end else if (rdup_q) begin
                    if (rs) begin
                        p_load  = 1'b1;
                        p_din   = hold_q;
                        rdup_d  = 1'b0;
                        right_d = 1'b1;
                        state_d = SHIFT;
                    end
`endif
                end else if (fs) begin
                    p_load = 1'b1;
                    last_d = (addr_q == END_ADDR);
                    if (addr_q != END_ADDR) addr_d = addr_q + 1'b1;
`ifdef STEREO_DUP_EN
                    hold_d  = next_q;
                    right_d = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!play) begin
                    // Drop the partial word and point back at it so resume replays it.
                    state_d = IDLE;
                    if (!last_q) addr_d = addr_q - 1'b1;
`ifdef STEREO_DUP_EN
                    rdup_d  = 1'b0;
                    right_d = 1'b0;
`endif
                end else begin
                    p_shift = 1'b1;
                    // Prefetch the next word during the first bit of a left word.
                    if ((p_cnt == CNT_W'(1)) && !last_q) rd_en = 1'b1;
`ifdef STEREO_DUP_EN
                    if (right_q) rd_en = 1'b0;
                    if (p_empty) begin
                        if (!right_q) begin
                            rdup_d  = 1'b1;
                            state_d = ARMED;
                        end else begin
                            state_d = last_q ? DONE : ARMED;
                        end
                    end
`else
                    if (p_empty) state_d = last_q ? DONE : ARMED;
`endif
                end
            end
            DONE: begin
                if (!play) begin
                    state_d = IDLE;
                    addr_d  = START_ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lrc_q     <= 1'b0;
            addr_q    <= START_ADDR;
            next_q    <= '0;
            last_q    <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lrc_q     <= daclrc;
            addr_q    <= addr_d;
            next_q    <= next_d;
            last_q    <= last_d;
            rd_pend_q <= rd_en;
        end
    end

`ifdef STEREO_DUP_EN
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            rdup_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            rdup_q  <= rdup_d;
            right_q <= right_d;
        end
    end
`endif

endmodule

// File: tb/tb_dac_playback.sv
// -----------------------------------------------------------------------------
// tb_dac_playback
// Directed bench for dac_playback (END_ADDR = 3). daclrc toggles every 32 bclk.
// A pull-up on addr makes a released (high-Z) bus read as all ones.
// Build with STEREO_DUP_EN to expect the right-channel copy.
// -----------------------------------------------------------------------------
module tb_dac_playback;

    localparam logic [17:0] ADDR_Z = 18'h3FFFF;

    logic        bclk;
    logic        rst_n;
    logic        daclrc;
    logic        play;
    logic [15:0] rd_data;
    wire  [17:0] addr;
    logic        rd_en;
    logic        dacdat;
    logic        busy;
    logic        done;

    pullup (addr);

    dac_playback #(
        .END_ADDR (18'd3)
    ) dut (
        .bclk    (bclk),
        .rst_n   (rst_n),
        .daclrc  (daclrc),
        .play    (play),
        .rd_data (rd_data),
        .addr    (addr),
        .rd_en   (rd_en),
        .dacdat  (dacdat),
        .busy    (busy),
        .done    (done)
    );

    int          n_chk;
    int          n_err;
    int          fs_cnt;
    int          lrc_div;
    int          rd_cnt;
    logic [17:0] rd_addr;
    logic        rd_pend;
    logic [2:0]  rd_idx;
    logic [15:0] mem [0:7];

    typedef struct {
        logic [15:0] word;
        int          rd_n;
        logic [17:0] rd_addr;
        logic [17:0] addr_after;
        logic        busy;
        logic        done;
    } frame_vec_t;

    frame_vec_t vec [4];

    initial begin
        bclk = 1'b0;
        forever #5 bclk = ~bclk;
    end

    // Frame clock: toggles 2 time units after every 32nd rising edge.
    initial begin
        daclrc  = 1'b1;
        lrc_div = 0;
        fs_cnt  = 0;
        forever begin
            @(posedge bclk);
            #2;
            lrc_div++;
            if (lrc_div == 32) begin
                lrc_div = 0;
                daclrc  = ~daclrc;
                if (!daclrc) fs_cnt++;
            end
        end
    end

    // SRAM model: data for a strobed address appears only in the following cycle.
    initial begin
        rd_data = 16'hDEAD;
        rd_pend = 1'b0;
        rd_idx  = '0;
        rd_cnt  = 0;
        rd_addr = '0;
        forever begin
            @(negedge bclk);
            rd_data = rd_pend ? mem[rd_idx] : 16'hDEAD;
            rd_pend = rd_en;
            if (rd_en) begin
                rd_cnt++;
                rd_addr = addr;
                rd_idx  = addr[2:0];
            end
        end
    end

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Returns one cycle after the edge that launches the first bit of a frame.
    task automatic wait_fs();
        int  start;
        bit  seen;
        start = fs_cnt;
        seen  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (fs_cnt != start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_fs: no frame start within 200 cycles");
        end
    endtask

    // 64 consecutive dacdat samples starting at the current cycle, first in bit 63.
    task automatic capture(output logic [63:0] v);
        v = '0;
        for (int i = 0; i < 64; i++) begin
            v[63-i] = dacdat;
            if (i != 63) tick();
        end
    endtask

    function automatic logic [63:0] frame_exp(input logic [15:0] w);
`ifdef STEREO_DUP_EN
        return {w, 16'h0000, w, 16'h0000};
`else
        return {w, 48'h0};
`endif
    endfunction

    initial begin
        logic [63:0] v;
        int          r0;

        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 8; i++) mem[i] = 16'h0000;

        vec[0] = '{word: 16'h0001, rd_n: 2, rd_addr: 18'd1, addr_after: 18'd1, busy: 1'b1, done: 1'b0};
        vec[1] = '{word: 16'h0002, rd_n: 1, rd_addr: 18'd2, addr_after: 18'd2, busy: 1'b1, done: 1'b0};
        vec[2] = '{word: 16'h0003, rd_n: 1, rd_addr: 18'd3, addr_after: 18'd3, busy: 1'b1, done: 1'b0};
        vec[3] = '{word: 16'h0004, rd_n: 0, rd_addr: 18'd0, addr_after: 18'd3, busy: 1'b0, done: 1'b1};

        // Reset state
        play  = 1'b0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_dacdat", 64'(dacdat), 64'd0);
        chk("reset_busy",   64'(busy),   64'd0);
        chk("reset_done",   64'(done),   64'd0);
        chk("reset_rd_en",  64'(rd_en),  64'd0);
        chk("reset_addr_z", 64'(addr),   64'(ADDR_Z));

        // First word A5C3 from address 0
        mem[0] = 16'hA5C3;
        mem[1] = 16'hFFFF;
        rst_n  = 1'b1;
        tick();
        chk("idle_addr_z", 64'(addr), 64'(ADDR_Z));
        wait_fs();
        play = 1'b1;
        #1;
        chk("play_addr_drive", 64'(addr), 64'd0);
        r0 = rd_cnt;
        repeat (4) tick();
        chk("fetch_rd_count", 64'(rd_cnt - r0), 64'd1);
        chk("fetch_rd_addr",  64'(rd_addr),     64'd0);
        chk("fetch_busy",     64'(busy),        64'd1);
        wait_fs();
        capture(v);
        chk("frame_a5c3", v, frame_exp(16'hA5C3));

        // Asynchronous reset in the middle of the FFFF word
        wait_fs();
        repeat (4) tick();
        chk("midword_dacdat", 64'(dacdat), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_dacdat", 64'(dacdat), 64'd0);
        chk("async_rst_busy",   64'(busy),   64'd0);
        chk("async_rst_done",   64'(done),   64'd0);
        chk("async_rst_rd_en",  64'(rd_en),  64'd0);
        chk("async_rst_addr_z", 64'(addr),   64'(ADDR_Z));
        repeat (3) tick();
        play   = 1'b0;
        mem[0] = 16'h0001;
        mem[1] = 16'h0002;
        mem[2] = 16'h0003;
        mem[3] = 16'h0004;
        rst_n  = 1'b1;
        tick();
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Four consecutive frames, addresses 0..3
        wait_fs();
        play = 1'b1;
        #1;
        chk("post_rst_addr", 64'(addr), 64'd0);
        for (int k = 0; k < 4; k++) begin
            r0 = rd_cnt;
            wait_fs();
            capture(v);
            chk($sformatf("frame%0d_data", k), v, frame_exp(vec[k].word));
            chk($sformatf("frame%0d_rd_count", k), 64'(rd_cnt - r0), 64'(vec[k].rd_n));
            if (vec[k].rd_n > 0)
                chk($sformatf("frame%0d_rd_addr", k), 64'(rd_addr), 64'(vec[k].rd_addr));
            chk($sformatf("frame%0d_addr", k), 64'(addr), 64'(vec[k].addr_after));
            chk($sformatf("frame%0d_busy", k), 64'(busy), 64'(vec[k].busy));
            chk($sformatf("frame%0d_done", k), 64'(done), 64'(vec[k].done));
        end

        // DONE holds: silent output, address parked on the last sample
        wait_fs();
        capture(v);
        chk("done_silent", v, 64'd0);
        chk("done_flag",   64'(done), 64'd1);
        chk("done_addr",   64'(addr), 64'd3);

        // Leave DONE, restart from START_ADDR
        mem[1] = 16'hFFFF;
        mem[2] = 16'h8001;
        play   = 1'b0;
        #1;
        chk("stop_addr_z", 64'(addr), 64'(ADDR_Z));
        tick();
        chk("stop_done", 64'(done), 64'd0);
        wait_fs();
        play = 1'b1;
        #1;
        chk("restart_addr", 64'(addr), 64'd0);

        // Pause at bit 7 of the address-1 word, then resume
        wait_fs();
        wait_fs();
        repeat (8) tick();
        chk("pause_pre_dacdat", 64'(dacdat), 64'd1);
        play = 1'b0;
        #1;
        chk("pause_addr_z", 64'(addr), 64'(ADDR_Z));
        tick();
        chk("pause_dacdat", 64'(dacdat), 64'd0);
        chk("pause_busy",   64'(busy),   64'd0);
        play = 1'b1;
        r0   = rd_cnt;
        repeat (4) tick();
        chk("resume_rd_count", 64'(rd_cnt - r0), 64'd1);
        chk("resume_rd_addr",  64'(rd_addr),     64'd1);
        wait_fs();
        capture(v);
        chk("resume_frame", v, frame_exp(16'hFFFF));
        chk("resume_addr",  64'(addr), 64'd2);

        // 8001: right phase either repeats the word or stays silent
        wait_fs();
        capture(v);
        chk("frame_8001", v, frame_exp(16'h8001));
        chk("frame_8001_addr", 64'(addr), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
